// File: rtl/ctrl_types_pkg.sv
// Operation and FSM encodings for the key/value cache controller.
package ctrl_types_pkg;

    typedef enum logic [if_types_pkg::RegOpWidth-1:0] {
        NOP    = 3'd0,
        GET    = 3'd1,
        PUT    = 3'd2,
        DELETE = 3'd3
    } operation_e;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } ctrl_state_e;

    // Completion write-back: busy drops, hit reported, operation field cleared.
    function automatic if_types_pkg::reg_write_t done_write(input logic hit);
        if_types_pkg::reg_write_t w;
        w                 = '0;
        w.busy_valid      = 1'b1;
        w.busy            = 1'b0;
        w.hit_valid       = 1'b1;
        w.hit             = hit;
        w.operation_valid = 1'b1;
        w.operation       = NOP;
        return w;
    endfunction

endpackage

// File: rtl/if_types_pkg.sv
// Register-interface types shared between the OBI register block and the cache controller.
package if_types_pkg;

    localparam int unsigned RegKeyWidth  = 16;
    localparam int unsigned RegDataWidth = 32;
    localparam int unsigned RegOpWidth   = 3;

    typedef struct packed {
        logic [RegDataWidth-1:0] dat;
        logic [RegKeyWidth-1:0]  key;
        logic [RegOpWidth-1:0]   operation;
    } reg_read_t;

    typedef struct packed {
        logic                    dat_valid;
        logic [RegDataWidth-1:0] dat;
        logic                    busy_valid;
        logic                    busy;
        logic                    hit_valid;
        logic                    hit;
        logic                    operation_valid;
        logic [RegOpWidth-1:0]   operation;
    } reg_write_t;

endpackage

// File: rtl/kv_entry_array.sv
// Fully-associative key/value storage: one combinational read port, one write port, async clear.
module kv_entry_array #(
    parameter  int unsigned NumEntries = 8,
    parameter  int unsigned KeyWidth   = 16,
    parameter  int unsigned DataWidth  = 32,
    localparam int unsigned IdxW       = $clog2(NumEntries)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IdxW-1:0]      raddr,
    output logic [KeyWidth-1:0]  rkey,
    output logic [DataWidth-1:0] rdata,
    output logic                 rvalid,
    input  logic                 we,
    input  logic [IdxW-1:0]      waddr,
    input  logic [KeyWidth-1:0]  wkey,
    input  logic [DataWidth-1:0] wdata,
    input  logic                 wvalid
);

    logic [KeyWidth-1:0]  key_q   [NumEntries];
    logic [DataWidth-1:0] data_q  [NumEntries];
    logic                 valid_q [NumEntries];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NumEntries; i++) begin
                key_q[i]   <= '0;
                data_q[i]  <= '0;
                valid_q[i] <= 1'b0;
            end
        end else if (we) begin
            key_q[waddr]   <= wkey;
            data_q[waddr]  <= wdata;
            valid_q[waddr] <= wvalid;
        end
    end

    assign rkey   = key_q[raddr];
    assign rdata  = data_q[raddr];
    assign rvalid = valid_q[raddr];

endmodule

// File: rtl/redis_cache_ctrl.sv
// GET/PUT/DELETE controller over a linear-scan key/value store, driven by the register snapshot.
// Optional REDIS_CACHE_STATS_EN adds saturating hit/miss counters as extra output ports.
module redis_cache_ctrl
    import if_types_pkg::*;
    import ctrl_types_pkg::*;
#(
    parameter int unsigned NumEntries = 8,
    parameter int unsigned KeyWidth   = RegKeyWidth,
    parameter int unsigned DataWidth  = RegDataWidth
) (
    input  logic       clk,
    input  logic       rst,
    input  reg_read_t  reg_read_i,
    output reg_write_t reg_write_o
`ifdef REDIS_CACHE_STATS_EN
    ,
    output logic [15:0] stat_hits_o,
    output logic [15:0] stat_misses_o
`endif
);

    localparam int unsigned     IdxW    = $clog2(NumEntries);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumEntries - 1);

    ctrl_state_e          state_q, state_d;
    operation_e           op_q, op_d;
    logic [KeyWidth-1:0]  key_q, key_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 free_found_q, free_found_d;
    logic [IdxW-1:0]      free_idx_q, free_idx_d;
    logic [IdxW-1:0]      evict_q, evict_d;
    reg_write_t           reg_write_q, reg_write_d;

    logic [KeyWidth-1:0]  rkey;
    logic [DataWidth-1:0] rdata;
    logic                 rvalid;
    logic                 match;
    logic                 we;
    logic [IdxW-1:0]      waddr;
    logic [KeyWidth-1:0]  wkey;
    logic [DataWidth-1:0] wdata;
    logic                 wvalid;

    kv_entry_array #(
        .NumEntries(NumEntries),
        .KeyWidth  (KeyWidth),
        .DataWidth (DataWidth)
    ) u_store (
        .clk   (clk),
        .rst   (rst),
        .raddr (idx_q),
        .rkey  (rkey),
        .rdata (rdata),
        .rvalid(rvalid),
        .we    (we),
        .waddr (waddr),
        .wkey  (wkey),
        .wdata (wdata),
        .wvalid(wvalid)
    );

    assign match = rvalid && (rkey == key_q);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        key_d        = key_q;
        data_d       = data_q;
        idx_d        = idx_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        evict_d      = evict_q;
        reg_write_d  = '0;
        we           = 1'b0;
        waddr        = idx_q;
        wkey         = key_q;
        wdata        = data_q;
        wvalid       = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (reg_read_i.operation inside {GET, PUT, DELETE}) begin
                    op_d                   = operation_e'(reg_read_i.operation);
                    key_d                  = KeyWidth'(reg_read_i.key);
                    data_d                 = DataWidth'(reg_read_i.dat);
                    idx_d                  = '0;
                    free_found_d           = 1'b0;
                    reg_write_d.busy_valid = 1'b1;
                    reg_write_d.busy       = 1'b1;
                    state_d                = SCAN;
                end
            end
            SCAN: begin
                if (match) begin
                    reg_write_d = done_write(1'b1);
                    unique case (op_q)
                        GET: begin
                            reg_write_d.dat_valid = 1'b1;
                            reg_write_d.dat       = RegDataWidth'(rdata);
                        end
                        PUT:     we = 1'b1;
                        DELETE: begin
                            we     = 1'b1;
                            wvalid = 1'b0;
                        end
                        default: ;
                    endcase
                    state_d = DONE;
                end else begin
                    if (!rvalid && !free_found_q) begin
                        free_found_d = 1'b1;
                        free_idx_d   = idx_q;
                    end
                    if (idx_q == LastIdx) begin
                        reg_write_d = done_write(1'b0);
                        // The last entry may itself be the first free slot, so it is folded in here.
                        if (op_q == PUT) begin
                            we = 1'b1;
                            if (free_found_q) begin
                                waddr = free_idx_q;
                            end else if (!rvalid) begin
                                waddr = idx_q;
                            end else begin
                                waddr   = evict_q;
                                evict_d = evict_q + 1'b1;
                            end
                        end
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= NOP;
            key_q        <= '0;
            data_q       <= '0;
            idx_q        <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            evict_q      <= '0;
            reg_write_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            key_q        <= key_d;
            data_q       <= data_d;
            idx_q        <= idx_d;
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            evict_q      <= evict_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign reg_write_o = reg_write_q;

`ifdef REDIS_CACHE_STATS_EN
    logic [15:0] hits_q, hits_d;
    logic [15:0] misses_q, misses_d;

    // The registered hit flag is live exactly during DONE, so it selects the counter.
    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (state_q == DONE) begin
            if (reg_write_q.hit) begin
                if (hits_q != '1) hits_d = hits_q + 16'd1;
            end else begin
                if (misses_q != '1) misses_d = misses_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
`endif

endmodule
